// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and helpers.
// The encoding keeps bit 1 equal to the debounced level Y.
package input_debouncer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    PEND_LOW    = 2'b10
  } state_t;

  // Y is high in STABLE_HIGH and in PEND_LOW, which is exactly bit 1 of the encoding
  function automatic logic level_of(input state_t st);
    return st[1];
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic multi-stage synchronizer for a single asynchronous bit.
// Synchronous active-high reset clears every stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], D};
    end
  end

  assign Q = stages[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw switch/button level: synchronize, then require DEBOUNCE_CYCLES
// consecutive equal samples before accepting a new level; edge pulses are registered.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic A,
  output logic Y,
  output logic Y_N,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             s;
  logic             next_y;
  logic             next_rise;
  logic             next_fall;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .D  (A),
    .Q  (s)
  );

  // All outputs are flops fed from next-state decode, so Y changes on the same
  // edge the FSM enters its new stable/pending state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      Y     <= 1'b0;
      Y_N   <= 1'b1;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      Y     <= next_y;
      Y_N   <= ~next_y;
      RISE  <= next_rise;
      FALL  <= next_fall;
    end
  end

  // A contrary sample in a pending state always wins over a full count, so any
  // excursion restarts from scratch with no credit carried over.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          next_state = PEND_HIGH;
          next_cnt   = CNT_ONE;
        end else begin
          next_cnt = '0;
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          next_state = PEND_LOW;
          next_cnt   = CNT_ONE;
        end else begin
          next_cnt = '0;
        end
      end
      PEND_LOW: begin
        if (s) begin
          next_state = STABLE_HIGH;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = STABLE_LOW;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state = STABLE_LOW;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    next_y    = level_of(next_state);
    next_rise = next_y & ~Y;
    next_fall = ~next_y & Y;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer at DEBOUNCE_CYCLES=4 and the
// minimum DEBOUNCE_CYCLES=2, both with SYNC_STAGES=2.
module tb_input_debouncer;
  import input_debouncer_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic a4, a2;
  logic y4, yn4, rise4, fall4;
  logic y2, yn2, rise2, fall2;
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  input_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) u4 (
    .CLK (CLK),
    .RST (RST),
    .A   (a4),
    .Y   (y4),
    .Y_N (yn4),
    .RISE(rise4),
    .FALL(fall4)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(2),
    .SYNC_STAGES    (2)
  ) u2 (
    .CLK (CLK),
    .RST (RST),
    .A   (a2),
    .Y   (y2),
    .Y_N (yn2),
    .RISE(rise2),
    .FALL(fall2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic a4_v, input logic a2_v);
    RST = rst_v;
    a4  = a4_v;
    a2  = a2_v;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput4(input string tag, input logic ey, input logic erise, input logic efall);
    checkBit({tag, ".Y"}, y4, ey);
    checkBit({tag, ".Y_N"}, yn4, ~ey);
    checkBit({tag, ".RISE"}, rise4, erise);
    checkBit({tag, ".FALL"}, fall4, efall);
  endtask

  task automatic checkOutput2(input string tag, input logic ey, input logic erise, input logic efall);
    checkBit({tag, ".Y"}, y2, ey);
    checkBit({tag, ".Y_N"}, yn2, ~ey);
    checkBit({tag, ".RISE"}, rise2, erise);
    checkBit({tag, ".FALL"}, fall2, efall);
  endtask

  task automatic run4(input string tag, input int n, input logic ey, input logic erise, input logic efall);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput4(tag, ey, erise, efall);
    end
  endtask

  task automatic run2(input string tag, input int n, input logic ey, input logic erise, input logic efall);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput2(tag, ey, erise, efall);
    end
  endtask

  initial begin
    $display("[TB] start");

    // Reset held for three edges with A already high
    applyStimulus(1'b1, 1'b1, 1'b0);
    run4("reset", 3, 1'b0, 1'b0, 1'b0);
    checkOutput2("reset_d2", 1'b0, 1'b0, 1'b0);
    checkBit("reset.state", u4.state == STABLE_LOW, 1'b1);
    checkBit("reset.cnt", u4.cnt == 2'd0, 1'b1);

    // Release: first release edge samples A, Y rises on the 5th edge after it
    applyStimulus(1'b0, 1'b1, 1'b0);
    run4("rst_release", 5, 1'b0, 1'b0, 1'b0);
    run4("rst_rise", 1, 1'b1, 1'b1, 1'b0);
    run4("rst_hold", 1, 1'b1, 1'b0, 1'b0);
    checkOutput2("d2_idle", 1'b0, 1'b0, 1'b0);

    // Falling glitch: 3 low samples, 1 high, then low held
    applyStimulus(1'b0, 1'b0, 1'b0);
    run4("fglitch_low", 3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run4("fglitch_high", 1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    run4("fglitch_wait", 5, 1'b1, 1'b0, 1'b0);
    run4("fglitch_fall", 1, 1'b0, 1'b0, 1'b1);
    run4("fglitch_hold", 1, 1'b0, 1'b0, 1'b0);

    // Bounce: high for three samples, then low
    applyStimulus(1'b0, 1'b1, 1'b0);
    run4("bounce_high", 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    run4("bounce_low", 2, 1'b0, 1'b0, 1'b0);
    checkBit("bounce.pend", u4.state == PEND_HIGH, 1'b1);
    checkBit("bounce.cnt3", u4.cnt == 2'd3, 1'b1);
    run4("bounce_reject", 1, 1'b0, 1'b0, 1'b0);
    checkBit("bounce.stable_low", u4.state == STABLE_LOW, 1'b1);

    // Clean rise right after the bounce must take the full time again
    applyStimulus(1'b0, 1'b1, 1'b0);
    run4("restart_wait", 5, 1'b0, 1'b0, 1'b0);
    run4("restart_rise", 1, 1'b1, 1'b1, 1'b0);
    run4("restart_hold", 1, 1'b1, 1'b0, 1'b0);

    // Clean fall
    applyStimulus(1'b0, 1'b0, 1'b0);
    run4("clean_fall_wait", 5, 1'b1, 1'b0, 1'b0);
    run4("clean_fall", 1, 1'b0, 1'b0, 1'b1);

    // Mid-count reset while PEND_HIGH with cnt=2
    applyStimulus(1'b0, 1'b1, 1'b0);
    run4("mid_pend", 4, 1'b0, 1'b0, 1'b0);
    checkBit("mid.pend", u4.state == PEND_HIGH, 1'b1);
    checkBit("mid.cnt2", u4.cnt == 2'd2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    run4("mid_rst", 1, 1'b0, 1'b0, 1'b0);
    checkBit("mid.state", u4.state == STABLE_LOW, 1'b1);
    checkBit("mid.cnt0", u4.cnt == 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run4("post_rst_wait", 5, 1'b0, 1'b0, 1'b0);
    run4("post_rst_rise", 1, 1'b1, 1'b1, 1'b0);
    run4("post_rst_hold", 1, 1'b1, 1'b0, 1'b0);

    // DEBOUNCE_CYCLES=2: one-sample pulse rejected, clean rise after 3 edges
    applyStimulus(1'b0, 1'b1, 1'b1);
    run2("d2_pulse", 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run2("d2_reject", 4, 1'b0, 1'b0, 1'b0);
    checkBit("d2.stable_low", u2.state == STABLE_LOW, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    run2("d2_wait", 3, 1'b0, 1'b0, 1'b0);
    run2("d2_rise", 1, 1'b1, 1'b1, 1'b0);
    run2("d2_hold", 1, 1'b1, 1'b0, 1'b0);
    checkOutput4("d4_still_high", 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples needed to accept a new level; legal range 2..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flip-flop depth; legal range 2..4.
REQ-003 SHALL have port CLK  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port A  input  1: raw asynchronous level (switch/button), possibly bouncing.
REQ-006 SHALL have port Y  output  1: debounced, synchronized level, registered.
REQ-007 SHALL have port Y_N  output  1: registered complement of Y, for direct feed to inverting logic.
REQ-008 SHALL have port RISE  output  1: one-cycle pulse when Y goes 0->1, registered.
REQ-009 SHALL have port FALL  output  1: one-cycle pulse when Y goes 1->0, registered.

Function
REQ-010 SHALL pass A through a SYNC_STAGES-deep flip-flop chain; the last stage output is s.
REQ-011 SHALL implement a four-state FSM with states STABLE_LOW, PEND_HIGH, STABLE_HIGH and PEND_LOW, plus a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 SHALL transition from STABLE_LOW to PEND_HIGH with cnt<=1 when s=1; otherwise it holds with cnt=0.
REQ-013 SHALL, in PEND_HIGH, go to STABLE_LOW with cnt<=0 (glitch rejected) when s=0, go to STABLE_HIGH with cnt<=0 when s=1 and cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-014 SHALL make STABLE_HIGH and PEND_LOW mirror REQ-012 and REQ-013 with the polarity of s inverted.
REQ-015 SHALL drive Y=1 exactly in STABLE_HIGH and PEND_LOW, and Y_N=~Y at all times including reset.
REQ-016 SHALL update Y at edge k0+SYNC_STAGES+DEBOUNCE_CYCLES-1 when A is first sampled at a new level at edge k0 and holds through edge k0+DEBOUNCE_CYCLES-1; shorter excursions SHALL leave Y unchanged.
REQ-017 SHALL assert RISE (or FALL) for exactly one cycle, namely the first cycle Y shows the new value; RISE and FALL SHALL never both be 1.
REQ-018 SHALL restart a pending count from cnt=1 on any later qualifying excursion, with no accumulated credit.
REQ-019 SHALL never let cnt exceed DEBOUNCE_CYCLES-1 or wrap.

Reset
REQ-020 SHALL, while RST=1 at an edge, set all sync flip-flops to 0, state to STABLE_LOW, cnt to 0, Y to 0, Y_N to 1 and RISE/FALL to 0.
REQ-021 SHALL discard any pending count on a mid-operation reset; after release, A=1 SHALL be handled as a fresh 0->1 change per REQ-016, including the RISE pulse.

Structure
REQ-022 SHALL place the state encoding localparams (2-bit: STABLE_LOW=00, PEND_HIGH=01, STABLE_HIGH=11, PEND_LOW=10) in a shared package/include input_debouncer_pkg.
REQ-023 SHALL instantiate the synchronizer chain as one sub-module, sync_chain (params STAGES; ports CLK, RST, D, Q), which is reusable elsewhere in the library.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-024 SHALL cover reset: A=1 with RST=1 for 3 edges -> Y=0, Y_N=1, RISE=FALL=0 throughout; after release, Y=1 at the 5th edge after the first release edge, with a single RISE pulse.
REQ-025 SHALL cover a clean rise: A 0->1 first sampled at edge 10 and held -> Y=1, Y_N=0 from edge 15, RISE=1 only in the cycle after edge 15, no FALL.
REQ-026 SHALL cover a bounce: A high for edges 10-12 then low -> Y stays 0, RISE never asserts, FSM returns to STABLE_LOW by edge 15.
REQ-027 SHALL cover a falling glitch: from Y=1, A low for 3 samples, high for 1, then low and held -> no FALL for the first excursion; FALL occurs 5 edges after the final low sample begins.
REQ-028 SHALL cover a mid-count reset: RST asserted while in PEND_HIGH with cnt=2 -> STABLE_LOW, cnt=0; with A still 1, Y rises 5 edges after the first post-reset sampling edge.
REQ-029 SHALL cover the minimum parameter: DEBOUNCE_CYCLES=2 with a clean rise -> Y updates 3 edges after capture, and a 1-sample pulse is rejected.
